// File: rtl/simple_wr_ram_pkg.sv
// Shared types for the simple dual-port RAM: names the two sources that can
// feed the registered read port.
package simple_wr_ram_pkg;

  typedef enum logic {
    RD_SRC_MEM    = 1'b0,
    RD_SRC_BYPASS = 1'b1
  } rd_src_e;

endpackage

// File: rtl/simple_wr_ram.sv
// Simple dual-port RAM: one registered read port (A) and one write port (B).
// A same-address read during a write returns the new data (write-first).
module simple_wr_ram
  import simple_wr_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_rddata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_we,
  input  logic [DATA_WIDTH-1:0] b_wrdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  rd_src_e               rd_src;
  logic [DATA_WIDTH-1:0] a_rddata_d;
  logic [DATA_WIDTH-1:0] a_rddata_q;

  always_comb begin
    rd_src     = RD_SRC_MEM;
    a_rddata_d = mem[a_addr];
    if (b_we && (b_addr == a_addr)) begin
      rd_src = RD_SRC_BYPASS;
    end
    if (rd_src == RD_SRC_BYPASS) begin
      a_rddata_d = b_wrdata;
    end
  end

  // Array stays reset-free so it maps to block RAM; rstn only blocks writes
  // at edges that fall inside reset, so stored words survive a reset pulse.
  always_ff @(posedge clk) begin
    if (rstn && b_we) begin
      mem[b_addr] <= b_wrdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rddata_q <= '0;
    end else begin
      a_rddata_q <= a_rddata_d;
    end
  end

  assign a_rddata = a_rddata_q;

endmodule

// File: tb/tb_simple_wr_ram.sv
// Scoreboard bench for simple_wr_ram: directed cases plus random traffic
// checked against an array model of the memory.
`timescale 1ns/1ps
module tb_simple_wr_ram;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_rddata;
  logic [AW-1:0] b_addr = '0;
  logic          b_we = 1'b0;
  logic [DW-1:0] b_wrdata = '0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          known;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem[DEPTH];
  bit            model_known[DEPTH];
  int            rd_idx = 0;

  simple_wr_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .a_addr   (a_addr),
    .a_rddata (a_rddata),
    .b_addr   (b_addr),
    .b_we     (b_we),
    .b_wrdata (b_wrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%02h required=0x%02h", name, act, req);
    end
  endtask

  // One cycle of stimulus; expected read result comes from the memory model.
  task automatic apply(input logic [AW-1:0] ra, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
    exp_t e;
    a_addr   = ra;
    b_we     = we;
    b_addr   = wa;
    b_wrdata = wd;
    if (rstn) begin
      if (we && wa == ra) begin
        e.known = 1'b1;
        e.val   = wd;
      end else begin
        e.known = model_known[ra];
        e.val   = model_mem[ra];
      end
      exp_q.push_back(e);
      if (we) begin
        model_mem[wa]   = wd;
        model_known[wa] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every active edge out of reset produces one read result.
  always @(posedge clk) begin
    if (rstn) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=0x%02h required=none", a_rddata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.known) check($sformatf("rd%0d", rd_idx), a_rddata, e.val);
        rd_idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

    // Reset held from time 0
    #3;
    check("reset_async", a_rddata, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", a_rddata, 8'h00);
    rstn = 1'b1;

    // Reads of unwritten words: undefined, not compared
    apply(2'd0, 1'b0, 2'd0, 8'h00);
    apply(2'd1, 1'b0, 2'd0, 8'h00);

    // Fill, then read back
    apply(2'd0, 1'b1, 2'd0, 8'h11);
    apply(2'd0, 1'b1, 2'd1, 8'h22);
    apply(2'd1, 1'b1, 2'd2, 8'h33);
    apply(2'd2, 1'b1, 2'd3, 8'h44);
    for (int i = 0; i < DEPTH; i++) apply(i[AW-1:0], 1'b0, 2'd0, 8'h00);

    // Same-address collision, then hold
    apply(2'd2, 1'b1, 2'd2, 8'hAA);
    apply(2'd2, 1'b0, 2'd0, 8'h00);
    // Different-address collision
    apply(2'd3, 1'b1, 2'd1, 8'h55);
    apply(2'd1, 1'b0, 2'd0, 8'h00);
    // Write enable low
    apply(2'd0, 1'b0, 2'd0, 8'hFF);
    apply(2'd0, 1'b0, 2'd0, 8'h00);

    // Reset mid-run with a write attempt that must be dropped
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midreset_async", a_rddata, 8'h00);
    apply(2'd3, 1'b1, 2'd3, 8'hEE);
    check("midreset_hold", a_rddata, 8'h00);
    rstn = 1'b1;
    apply(2'd3, 1'b0, 2'd0, 8'h00);
    apply(2'd1, 1'b0, 2'd0, 8'h00);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      apply(AW'($urandom_range(DEPTH - 1)), 1'($urandom_range(1)),
            AW'($urandom_range(DEPTH - 1)), DW'($urandom));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
